// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU.
//   OP_*   : 3-bit operation encodings (000-100 match the single-cycle ALU)
//   FLG_*  : bit positions inside the 8-bit flag vector {S,V,ERR,AC,0,P,Z,C}
//   state_e: control FSM states
package alu_mc_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SHR = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_ROR = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   localparam int unsigned FLG_C   = 0;
   localparam int unsigned FLG_Z   = 1;
   localparam int unsigned FLG_P   = 2;
   localparam int unsigned FLG_AC  = 4;
   localparam int unsigned FLG_ERR = 5;
   localparam int unsigned FLG_V   = 6;
   localparam int unsigned FLG_S   = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mc_addcore.sv
// Combinational WIDTH-bit adder with carry-in.
//   a, b : addends
//   cin  : carry-in
//   sum  : WIDTH-bit sum
//   cout : carry out of the MSB
//   aux  : carry out of bit 3 (half-carry)
//   ovf  : two's-complement overflow
module alu_mc_addcore
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             aux,
   output logic             ovf
);

   logic [WIDTH:0] full;
   logic [4:0]     low;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      low  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
      sum  = full[WIDTH-1:0];
      cout = full[WIDTH];
      aux  = low[4];
      // Same-sign operands producing a different-sign result
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake (ready only while idle)
//   opsel, a, x          : operation and operands
//   a_inv, x_inv, op_inv : operand / result inversion controls
//   carry_in             : adder carry-in / shift fill bit
//   out_valid / out_ready: result handshake
//   z, z_hi, flags       : result, MUL high half, {S,V,ERR,AC,0,P,Z,C}
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opsel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] x,
   input  logic             a_inv,
   input  logic             x_inv,
   input  logic             op_inv,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] z_hi,
   output logic [7:0]       flags
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, x_q;
   logic [WIDTH-1:0] hi_q, lo_q;   // MUL {hi,lo} accumulator; lo_q also rotates for ROR
   logic             op_inv_q, cin_q, rc_q;
   logic [WIDTH-1:0] z_q, z_hi_q;
   logic [7:0]       flags_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] a_sel, x_sel;
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_cout, add_aux, add_ovf;
   logic [WIDTH-1:0] res_z, res_z_hi;
   logic [7:0]       res_flags;
   logic             res_c, res_ac, res_v, res_zero;

   assign a_sel = a_inv ? ~a : a;
   assign x_sel = x_inv ? ~x : x;

   // The adder is shared: MUL partial sums while iterating, otherwise the ADD op.
   always_comb begin
      add_a   = a_q;
      add_b   = x_q;
      add_cin = cin_q;
      if (op_q == OP_MUL) begin
         add_a   = hi_q;
         add_b   = lo_q[0] ? a_q : '0;
         add_cin = 1'b0;
      end
   end

   alu_mc_addcore #(
      .WIDTH(WIDTH)
   ) u_addcore (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout),
      .aux  (add_aux),
      .ovf  (add_ovf)
   );

   // Final result, valid in the last EXEC cycle (cnt_q == 0)
   always_comb begin
      res_z    = '0;
      res_z_hi = '0;
      res_c    = 1'b0;
      res_ac   = 1'b0;
      res_v    = 1'b0;
      unique case (op_q)
         OP_AND: res_z = (a_q & x_q) ^ {WIDTH{op_inv_q}};
         OP_XOR: res_z = (a_q ^ x_q) ^ {WIDTH{op_inv_q}};
         OP_ADD: begin
            res_z  = add_sum;
            res_c  = add_cout;
            res_ac = add_aux;
            res_v  = add_ovf;
         end
         OP_SHR: begin
            res_z = {cin_q, a_q[WIDTH-1:1]};
            res_c = a_q[0];
         end
         OP_SHL: begin
            res_z = {a_q[WIDTH-2:0], cin_q};
            res_c = a_q[WIDTH-1];
         end
         OP_MUL: begin
            res_z    = lo_q;
            res_z_hi = hi_q;
            res_c    = |hi_q;
         end
         OP_ROR: begin
            res_z = lo_q;
            res_c = rc_q;
         end
         OP_ILL: res_z = '0;
      endcase

      res_zero = (op_q == OP_MUL) ? ({hi_q, lo_q} == '0) : (res_z == '0);

      res_flags = '0;
      if (op_q == OP_ILL) begin
         res_flags[FLG_ERR] = 1'b1;
      end else begin
         res_flags[FLG_S]  = res_z[WIDTH-1];
         res_flags[FLG_V]  = res_v;
         res_flags[FLG_AC] = res_ac;
         res_flags[FLG_P]  = ~^res_z;
         res_flags[FLG_Z]  = res_zero;
         res_flags[FLG_C]  = res_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= OP_AND;
         a_q         <= '0;
         x_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         op_inv_q    <= 1'b0;
         cin_q       <= 1'b0;
         rc_q        <= 1'b0;
         z_q         <= '0;
         z_hi_q      <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q      <= a_sel;
                  x_q      <= x_sel;
                  op_q     <= opsel;
                  op_inv_q <= op_inv;
                  cin_q    <= carry_in;
                  rc_q     <= 1'b0;
                  hi_q     <= '0;
                  lo_q     <= (opsel == OP_ROR) ? a_sel : x_sel;
                  // ROR amount comes from raw x, never from the inverted operand
                  if (opsel == OP_MUL)      cnt_q <= CW'(WIDTH);
                  else if (opsel == OP_ROR) cnt_q <= CW'(x[SHW-1:0]);
                  else                      cnt_q <= '0;
                  state_q  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q == '0) begin
                  z_q         <= res_z;
                  z_hi_q      <= res_z_hi;
                  flags_q     <= res_flags;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
                  if (op_q == OP_MUL) begin
                     // Add multiplicand if multiplier LSB set, then shift {cout,hi,lo} right
                     hi_q <= {add_cout, add_sum[WIDTH-1:1]};
                     lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
                  end else if (op_q == OP_ROR) begin
                     lo_q <= {lo_q[0], lo_q[WIDTH-1:1]};
                     rc_q <= lo_q[0];
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign z_hi      = z_hi_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, sel16, out_ready;
   logic [2:0]  opsel;
   logic [15:0] a, x;
   logic        a_inv, x_inv, op_inv, carry_in;

   logic        iv8, iv16, ir8, ir16, ov8, ov16;
   logic [7:0]  z8, zh8, f8, f16;
   logic [15:0] z16, zh16;

   logic        obs_valid, obs_ready;
   logic [15:0] obs_z, obs_zh;
   logic [7:0]  obs_fl;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign iv8       = in_valid & ~sel16;
   assign iv16      = in_valid & sel16;
   assign obs_valid = sel16 ? ov16 : ov8;
   assign obs_ready = sel16 ? ir16 : ir8;
   assign obs_z     = sel16 ? z16 : {8'h00, z8};
   assign obs_zh    = sel16 ? zh16 : {8'h00, zh8};
   assign obs_fl    = sel16 ? f16 : f8;

   alu_mc #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .opsel(opsel),
      .a(a[7:0]), .x(x[7:0]), .a_inv(a_inv), .x_inv(x_inv), .op_inv(op_inv),
      .carry_in(carry_in), .out_valid(ov8), .out_ready(out_ready), .z(z8), .z_hi(zh8),
      .flags(f8)
   );

   alu_mc #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .opsel(opsel),
      .a(a), .x(x), .a_inv(a_inv), .x_inv(x_inv), .op_inv(op_inv),
      .carry_in(carry_in), .out_valid(ov16), .out_ready(out_ready), .z(z16), .z_hi(zh16),
      .flags(f16)
   );

   // Reference: whole-word arithmetic on wide integers
   task automatic model(input int w, input logic [2:0] op, input logic [15:0] av, xv,
                        input bit ai, xi, oi, ci, output logic [15:0] ez, ezh,
                        output logic [7:0] ef, output int el);
      longint mask, half, ua, ux, r, sa, sx, ss, cil;
      int amt;
      bit c, ac, v, s, p, zr;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      cil  = ci ? 1 : 0;
      ua   = ai ? (~longint'(av)) & mask : longint'(av) & mask;
      ux   = xi ? (~longint'(xv)) & mask : longint'(xv) & mask;
      amt  = int'(xv) & (w - 1);
      c = 0; ac = 0; v = 0; r = 0; el = 1;
      case (op)
         3'd0: r = (ua & ux) ^ (oi ? mask : 0);
         3'd1: r = (ua ^ ux) ^ (oi ? mask : 0);
         3'd2: begin
            r  = ua + ux + cil;
            c  = ((r >> w) & 1) != 0;
            ac = ((((ua & 15) + (ux & 15) + cil) >> 4) & 1) != 0;
            sa = (ua >= half) ? ua - 2 * half : ua;
            sx = (ux >= half) ? ux - 2 * half : ux;
            ss = sa + sx + cil;
            v  = (ss > half - 1) || (ss < -half);
         end
         3'd3: begin r = (cil << (w - 1)) | (ua >> 1); c = (ua & 1) != 0; end
         3'd4: begin r = (ua << 1) | cil; c = ((ua >> (w - 1)) & 1) != 0; end
         3'd5: begin r = ua * ux; c = (r >> w) != 0; el = w + 1; end
         3'd6: begin
            r  = ((ua >> amt) | (ua << (w - amt))) & mask;
            c  = (amt != 0) ? (((ua >> (amt - 1)) & 1) != 0) : 1'b0;
            el = amt + 1;
         end
         default: r = 0;
      endcase
      ez  = 16'(r & mask);
      ezh = (op == 3'd5) ? 16'((r >> w) & mask) : 16'h0000;
      s   = ((r >> (w - 1)) & 1) != 0;
      p   = ~^ez;
      zr  = (op == 3'd5) ? (r == 0) : (ez == 16'h0000);
      if (op == 3'd7) ef = 8'h20;
      else            ef = {s, v, 1'b0, ac, 1'b0, p, zr, c};
   endtask

   // Drive one op on the selected width, wait for the result, then hand it off
   task automatic do_op(input int w, input logic [2:0] op, input logic [15:0] av, xv,
                        input bit ai, xi, oi, ci, output logic [15:0] rz, rzh,
                        output logic [7:0] rf, output int lat);
      @(negedge clk);
      sel16 = (w == 16); opsel = op; a = av; x = xv;
      a_inv = ai; x_inv = xi; op_inv = oi; carry_in = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble inputs: the DUT must have captured them at accept
      opsel = 3'($urandom); a = 16'($urandom); x = 16'($urandom);
      a_inv = 1'($urandom); x_inv = 1'($urandom); op_inv = 1'($urandom);
      carry_in = 1'($urandom);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!obs_valid && lat < 100);
      rz = obs_z; rzh = obs_zh; rf = obs_fl;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] rz, rzh;
      logic [7:0]  rf;
      int lat;
      bit seen;
      n_checks++; if (ov8 !== 1'b0 || ov16 !== 1'b0)
         $display("FAIL reset_valid: got %b/%b want 0/0", ov8, ov16); else n_pass++;
      n_checks++; if (z8 !== 8'h00 || z16 !== 16'h0 || zh16 !== 16'h0)
         $display("FAIL reset_z: got %h/%h/%h want 0", z8, z16, zh16); else n_pass++;
      n_checks++; if (f8 !== 8'h00 || f16 !== 8'h00)
         $display("FAIL reset_flags: got %h/%h want 00", f8, f16); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (ir8 !== 1'b1 || ir16 !== 1'b1)
         $display("FAIL reset_ready: got %b/%b want 1/1", ir8, ir16); else n_pass++;
      // Leave nonzero state behind, then abort a MUL three cycles in
      do_op(8, 3'd2, 16'h0F, 16'h01, 0, 0, 0, 0, rz, rzh, rf, lat);
      @(negedge clk);
      sel16 = 1'b0; opsel = 3'd5; a = 16'hFF; x = 16'hFF;
      a_inv = 0; x_inv = 0; op_inv = 0; carry_in = 0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      n_checks++; if (ov8 !== 1'b0 || z8 !== 8'h00)
         $display("FAIL reset_async: got valid %b z %h want 0 00", ov8, z8); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (z8 !== 8'h00 || zh8 !== 8'h00 || f8 !== 8'h00)
         $display("FAIL reset_midmul_out: got z %h zh %h f %h want 0", z8, zh8, f8);
      else n_pass++;
      n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0)
         $display("FAIL reset_midmul_hs: got ready %b valid %b want 1 0", ir8, ov8);
      else n_pass++;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (ov8) seen = 1; end
      n_checks++; if (seen !== 1'b0)
         $display("FAIL reset_abandon: got late out_valid %b want 0", seen); else n_pass++;
   endtask

   task automatic test_add();
      logic [15:0] rz, rzh;
      logic [7:0]  rf;
      int lat;
      do_op(8, 3'd2, 16'h0F, 16'h01, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h10 || rf !== 8'h10 || lat !== 1)
         $display("FAIL add_ac: got z %h f %h lat %0d want 10 10 1", rz, rf, lat); else n_pass++;
      do_op(8, 3'd2, 16'h7F, 16'h01, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h80 || rf !== 8'hD0)
         $display("FAIL add_ovf: got z %h f %h want 80 d0", rz, rf); else n_pass++;
      do_op(8, 3'd2, 16'h01, 16'h01, 0, 1, 0, 1, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h00 || rf !== 8'h17 || rzh !== 16'h0)
         $display("FAIL add_zero: got z %h f %h zh %h want 00 17 0", rz, rf, rzh); else n_pass++;
   endtask

   task automatic test_mul();
      logic [15:0] rz, rzh;
      logic [7:0]  rf;
      int lat;
      do_op(8, 3'd5, 16'hFF, 16'hFF, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if ({rzh[7:0], rz[7:0]} !== 16'hFE01 || rf !== 8'h01 || lat !== 9)
         $display("FAIL mul8: got %h%h f %h lat %0d want fe01 01 9", rzh[7:0], rz[7:0], rf, lat);
      else n_pass++;
      do_op(16, 3'd5, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if ({rzh, rz} !== 32'hFFFE0001 || rf !== 8'h01 || lat !== 17)
         $display("FAIL mul16: got %h%h f %h lat %0d want fffe0001 01 17", rzh, rz, rf, lat);
      else n_pass++;
   endtask

   task automatic test_ror();
      logic [15:0] rz, rzh;
      logic [7:0]  rf;
      int lat;
      do_op(8, 3'd6, 16'h81, 16'h03, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h30 || rf !== 8'h04 || lat !== 4)
         $display("FAIL ror3: got z %h f %h lat %0d want 30 04 4", rz, rf, lat); else n_pass++;
      do_op(8, 3'd6, 16'h81, 16'h00, 0, 0, 0, 0, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h81 || rf !== 8'h84 || lat !== 1)
         $display("FAIL ror0: got z %h f %h lat %0d want 81 84 1", rz, rf, lat); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [15:0] rz, rzh;
      logic [7:0]  rf;
      int lat, bad;
      @(negedge clk);
      sel16 = 1'b0; opsel = 3'd2; a = 16'h35; x = 16'h4B;
      a_inv = 0; x_inv = 0; op_inv = 0; carry_in = 0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!ov8 && lat < 100);
      n_checks++; if (ov8 !== 1'b1 || z8 !== 8'h80 || f8 !== 8'hD0)
         $display("FAIL bp_result: got v %b z %h f %h want 1 80 d0", ov8, z8, f8); else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; opsel = 3'd0; a = 16'($urandom); x = 16'($urandom);
         @(posedge clk); #1;
         if (z8 !== 8'h80 || f8 !== 8'hD0 || ir8 !== 1'b0 || ov8 !== 1'b1) bad++;
      end
      n_checks++; if (bad !== 0)
         $display("FAIL bp_hold: got %0d bad cycles want 0 (z %h f %h)", bad, z8, f8);
      else n_pass++;
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      n_checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1 || z8 !== 8'h80)
         $display("FAIL bp_handoff: got v %b r %b z %h want 0 1 80", ov8, ir8, z8);
      else n_pass++;
      do_op(8, 3'd7, 16'h5A, 16'hA5, 1, 1, 1, 1, rz, rzh, rf, lat);
      n_checks++; if (rz !== 16'h00 || rf !== 8'h20 || lat !== 1)
         $display("FAIL illegal: got z %h f %h lat %0d want 00 20 1", rz, rf, lat); else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] rz, rzh, ez, ezh, av, xv;
      logic [7:0]  rf, ef;
      logic [2:0]  op;
      bit ai, xi, oi, ci;
      int lat, el, w;
      for (int i = 0; i < 48; i++) begin
         w  = (i % 3 == 2) ? 16 : 8;
         op = 3'($urandom_range(0, 7));
         av = 16'($urandom); xv = 16'($urandom);
         ai = 1'($urandom); xi = 1'($urandom); oi = 1'($urandom); ci = 1'($urandom);
         model(w, op, av, xv, ai, xi, oi, ci, ez, ezh, ef, el);
         do_op(w, op, av, xv, ai, xi, oi, ci, rz, rzh, rf, lat);
         n_checks++; if (rz !== ez)
            $display("FAIL rand_z w%0d op%0d: got %h want %h", w, op, rz, ez); else n_pass++;
         n_checks++; if (rzh !== ezh)
            $display("FAIL rand_zhi w%0d op%0d: got %h want %h", w, op, rzh, ezh); else n_pass++;
         n_checks++; if (rf !== ef)
            $display("FAIL rand_flags w%0d op%0d: got %h want %h", w, op, rf, ef); else n_pass++;
         n_checks++; if (lat !== el)
            $display("FAIL rand_lat w%0d op%0d: got %0d want %0d", w, op, lat, el); else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel16 = 1'b0; opsel = 3'd0;
      a = '0; x = '0; a_inv = 0; x_inv = 0; op_inv = 0; carry_in = 0;
      #1;
      test_reset();
      test_add();
      test_mul();
      test_ror();
      test_backpressure();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
